// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: entry layout, zero-register id, tag helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rob_pkg;

    localparam int ENTRY_DATA_W = 32;

    // Architectural r31 always reads zero; writes to it never retire.
    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic                    valid;
        logic                    done;
        logic                    regWrite;
        logic [4:0]              dest;
        logic [ENTRY_DATA_W-1:0] data;
    } rob_entry_t;

    // Tags are 1-based so that tag 0 can mean "value lives in the register file".
    function automatic int tag_to_idx(input int tag);
        return tag - 1;
    endfunction

endpackage

// File: rtl/decoder5x32.sv
// 5-to-32 one-hot decoder with enable; all zeros when disabled.
// Latency: combinational.
// Backpressure: none.
// Ports: en_i enable, addr_i select, onehot_o decoded vector.
module decoder5x32 (
    input  logic        en_i,
    input  logic [4:0]  addr_i,
    output logic [31:0] onehot_o
);

    always_comb begin
        onehot_o = 32'd0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder buffer: allocates tags at decode, marks entries done on writeback, retires in order.
// Latency: alloc/complete visible next cycle; commit_valid_o and resets_o combinational from state.
// Backpressure: alloc_ready_o drops when full or flushing; commit waits on commit_ready_i.
// Ports: alloc_* decode side, complete_* writeback bus, commit_* register file side,
//        commitReadAddr_o/commitReadData_i map-table commit read, resets_o map-table clears,
//        flush_i squash of all in-flight entries.
module rob_commit_ctrl
    import rob_pkg::*;
#(
    parameter int ROB_SIZE = 32,
    parameter int TAG_W    = $clog2(ROB_SIZE + 1),
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alloc_valid_i,
    input  logic              alloc_regWrite_i,
    input  logic [4:0]        alloc_dest_i,
    output logic              alloc_ready_o,
    output logic [TAG_W-1:0]  alloc_tag_o,
    input  logic              complete_valid_i,
    input  logic [TAG_W-1:0]  complete_tag_i,
    input  logic [DATA_W-1:0] complete_data_i,
    output logic              commit_valid_o,
    input  logic              commit_ready_i,
    output logic              commit_regWrite_o,
    output logic [4:0]        commit_dest_o,
    output logic [DATA_W-1:0] commit_data_o,
    output logic [4:0]        commitReadAddr_o,
    input  logic [TAG_W-1:0]  commitReadData_i,
    input  logic              flush_i,
    output logic [31:0]       resets_o
);

    localparam int IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
    localparam logic [TAG_W-1:0] FULL_CNT = TAG_W'(ROB_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROB_SIZE - 1);

    rob_entry_t        entries [ROB_SIZE];
    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  tail;
    logic [TAG_W-1:0]  count;

    logic              alloc_fire;
    logic              commit_fire;
    logic              comp_hit;
    logic [IDX_W-1:0]  comp_idx;
    logic [TAG_W-1:0]  head_tag;
    logic              commit_reset_en;
    logic [31:0]       commit_onehot;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Readiness uses registered count only, so a retiring entry frees its slot a cycle later.
    assign alloc_ready_o  = (count != FULL_CNT) & ~flush_i;
    assign alloc_tag_o    = TAG_W'(tail) + 1'b1;
    assign alloc_fire     = alloc_valid_i & alloc_ready_o;

    assign head_tag       = TAG_W'(head) + 1'b1;
    assign commit_valid_o = entries[head].valid & entries[head].done & ~flush_i;
    assign commit_fire    = commit_valid_o & commit_ready_i;

    assign commit_regWrite_o = entries[head].regWrite;
    assign commit_dest_o     = entries[head].dest;
    assign commit_data_o     = DATA_W'(entries[head].data);
    assign commitReadAddr_o  = entries[head].dest;

    // The slot being allocated this cycle is still invalid here, so a same-cycle
    // completion to it falls out of the valid check without a special case.
    assign comp_idx = IDX_W'(tag_to_idx(int'(complete_tag_i)));
    assign comp_hit = complete_valid_i & ~flush_i
                    & (complete_tag_i != '0)
                    & (complete_tag_i <= FULL_CNT)
                    & entries[comp_idx].valid;

    // Clear the map entry only if it still names this tag; a younger rename keeps its mapping.
    assign commit_reset_en = commit_fire & entries[head].regWrite & (commitReadData_i == head_tag);

    decoder5x32 u_reset_dec (
        .en_i     (commit_reset_en),
        .addr_i   (entries[head].dest),
        .onehot_o (commit_onehot)
    );

    assign resets_o = commit_onehot | {32{flush_i}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i] <= '0;
            end
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
        end else begin
            if (comp_hit) begin
                entries[comp_idx].done <= 1'b1;
                entries[comp_idx].data <= ENTRY_DATA_W'(complete_data_i);
            end
            if (commit_fire) begin
                entries[head].valid <= 1'b0;
                head <= ptr_inc(head);
            end
            if (alloc_fire) begin
                entries[tail].valid    <= 1'b1;
                entries[tail].done     <= 1'b0;
                entries[tail].regWrite <= alloc_regWrite_i & (alloc_dest_i != ZERO_REG);
                entries[tail].dest     <= alloc_dest_i;
                tail <= ptr_inc(tail);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
